// File: rtl/core_instruction_issuer_if.sv
// Instruction bus between the issuer (master) and one compute core (slave).
// The core raises busy while it executes the word strobed by cpen.
interface core_instruction_issuer_if #(
   parameter int INSTRUCTION_WIDTH = 15
);
   logic [INSTRUCTION_WIDTH-1:0] instruction;
   logic                         cpen;
   logic                         busy;

   modport master (
      output instruction,
      output cpen,
      input  busy
   );

   modport slave (
      input  instruction,
      input  cpen,
      output busy
   );
endinterface

// File: rtl/core_instruction_issuer.sv
// Sequential instruction issuer: fetches start_pc..stop_pc from program memory and
// hands each word to the core, waiting on busy. Define ISSUE_COUNT_EN for issue_count.
module core_instruction_issuer #(
   parameter int                           INSTRUCTION_WIDTH = 15,
   parameter int                           PC_WIDTH          = 8,
   parameter logic [INSTRUCTION_WIDTH-1:0] NOP_WORD          = 15'h02C0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         abort,
   input  logic [PC_WIDTH-1:0]          start_pc,
   input  logic [PC_WIDTH-1:0]          stop_pc,
   output logic [PC_WIDTH-1:0]          imem_addr,
   output logic                         imem_rd,
   input  logic [INSTRUCTION_WIDTH-1:0] imem_q,
   core_instruction_issuer_if.master    core,
   output logic                         running,
   output logic                         done,
   output logic [15:0]                  issue_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_Q,
      S_ISSUE,
      S_WAIT_BUSY,
      S_DONE
   } state_t;

   localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

   state_t                       state_reg, state_next;
   logic [PC_WIDTH-1:0]          pc_reg, pc_next;
   logic [PC_WIDTH-1:0]          stop_reg, stop_next;
   logic                         sampled_reg, sampled_next;

   logic [PC_WIDTH-1:0]          imem_addr_reg, imem_addr_next;
   logic                         imem_rd_reg, imem_rd_next;
   logic [INSTRUCTION_WIDTH-1:0] instruction_reg, instruction_next;
   logic                         cpen_reg, cpen_next;
   logic                         running_reg, running_next;
   logic                         done_reg, done_next;

   // State, datapath and registered outputs share one register process.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= S_IDLE;
         pc_reg          <= '0;
         stop_reg        <= '0;
         sampled_reg     <= 1'b0;
         imem_addr_reg   <= '0;
         imem_rd_reg     <= 1'b0;
         instruction_reg <= NOP_WORD;
         cpen_reg        <= 1'b0;
         running_reg     <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         stop_reg        <= stop_next;
         sampled_reg     <= sampled_next;
         imem_addr_reg   <= imem_addr_next;
         imem_rd_reg     <= imem_rd_next;
         instruction_reg <= instruction_next;
         cpen_reg        <= cpen_next;
         running_reg     <= running_next;
         done_reg        <= done_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      stop_next    = stop_reg;
      // The first WAIT_BUSY cycle only lets a late busy from the core arrive.
      sampled_next = (state_reg == S_WAIT_BUSY);
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_FETCH;
               pc_next    = start_pc;
               stop_next  = stop_pc;
            end
         end
         S_FETCH:  state_next = S_WAIT_Q;
         S_WAIT_Q: state_next = S_ISSUE;
         S_ISSUE:  state_next = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (sampled_reg && !core.busy) begin
               if (pc_reg == stop_reg) begin
                  state_next = S_DONE;
               end else begin
                  state_next = S_FETCH;
                  pc_next    = pc_reg + PC_ONE;
               end
            end
         end
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
      if (abort) begin
         state_next = S_IDLE;
      end
   end

   // Outputs are derived from the upcoming state so they line up with it once registered.
   always_comb begin
      imem_rd_next     = (state_next == S_FETCH);
      imem_addr_next   = (state_next == S_FETCH) ? pc_next : imem_addr_reg;
      cpen_next        = (state_next == S_ISSUE);
      running_next     = (state_next != S_IDLE);
      done_next        = (state_next == S_DONE);
      instruction_next = instruction_reg;
      if (state_next == S_IDLE || state_next == S_DONE) begin
         instruction_next = NOP_WORD;
      end else if (state_reg == S_WAIT_Q) begin
         instruction_next = imem_q;
      end
   end

   assign imem_addr        = imem_addr_reg;
   assign imem_rd          = imem_rd_reg;
   assign core.instruction = instruction_reg;
   assign core.cpen        = cpen_reg;
   assign running          = running_reg;
   assign done             = done_reg;

`ifdef ISSUE_COUNT_EN
   logic [15:0] count_reg, count_next;

   always_comb begin
      count_next = count_reg;
      if (state_reg == S_IDLE && state_next == S_FETCH) begin
         count_next = '0;
      end else if (cpen_reg && count_reg != 16'hFFFF) begin
         count_next = count_reg + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign issue_count = count_reg;
`else
   assign issue_count = 16'h0000;
`endif

endmodule

// File: tb/tb_core_instruction_issuer.sv
// Directed bench for core_instruction_issuer: a timeline model predicts every output
// cycle by cycle; literal expectations pin issued words, spacing, addresses and counts.
module tb_core_instruction_issuer;

   localparam logic [14:0] NOP = 15'h02C0;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [7:0]  start_pc;
   logic [7:0]  stop_pc;
   logic [7:0]  imem_addr;
   logic        imem_rd;
   logic [14:0] imem_q;
   logic        running;
   logic        done;
   logic [15:0] issue_count;

   core_instruction_issuer_if bus ();

   core_instruction_issuer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .start_pc    (start_pc),
      .stop_pc     (stop_pc),
      .imem_addr   (imem_addr),
      .imem_rd     (imem_rd),
      .imem_q      (imem_q),
      .core        (bus),
      .running     (running),
      .done        (done),
      .issue_count (issue_count)
   );

   always #5 clk = ~clk;

   logic [14:0] mem [256];
   always @(posedge clk) begin
      if (imem_rd) imem_q <= mem[imem_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_cnt(input int n);
`ifdef ISSUE_COUNT_EN
      return 32'(n);
`else
      return 32'(n * 0);
`endif
   endfunction

   // Core model: busy rises with cpen and stays high for busy_hold cycles in total.
   int busy_hold = 0;
   int bcnt = 0;
   always @(negedge clk) begin
      if (bus.cpen) bcnt = busy_hold;
      else if (bcnt > 0) bcnt--;
      bus.busy = (bcnt > 0);
   end

   // Timeline model: issue i occupies P cycles from A + i*P (fetch, q, issue, wait),
   // then one done cycle; an abort sampled at the end of cycle m_ab ends the run.
   bit         chk_on = 0;
   bit         m_en = 0;
   int         m_A, m_n, m_P, m_ab;
   logic [7:0] m_start;

   int          q_rd_addr[$];
   int          q_cpen_cyc[$];
   logic [14:0] q_cpen_word[$];
   int          done_cnt = 0;

   int          rel, idx, ph;
   bit          e_idle, e_rd, e_cpen, e_done;
   logic [7:0]  e_addr;

   always @(negedge clk) begin
      if (chk_on) begin
         e_idle = 1; e_rd = 0; e_cpen = 0; e_done = 0; e_addr = '0;
         if (m_en) begin
            rel = cyc - m_A;
            if (rel >= 0 && rel <= m_n * m_P && (m_ab < 0 || cyc <= m_ab)) begin
               e_idle = 0;
               idx = rel / m_P;
               ph  = rel % m_P;
               if (idx < m_n) begin
                  e_rd   = (ph == 0);
                  e_cpen = (ph == 2);
                  e_addr = m_start + idx[7:0];
               end else begin
                  e_done = 1;
               end
            end
         end
         chk("running", 32'(running), 32'(!e_idle));
         chk("cpen", 32'(bus.cpen), 32'(e_cpen));
         chk("imem_rd", 32'(imem_rd), 32'(e_rd));
         chk("done", 32'(done), 32'(e_done));
         if (e_rd)   chk("imem_addr", 32'(imem_addr), 32'(e_addr));
         if (e_cpen) chk("instruction", 32'(bus.instruction), 32'(mem[e_addr]));
         if (e_idle) chk("idle_instruction", 32'(bus.instruction), 32'(NOP));
         if (imem_rd) q_rd_addr.push_back(int'(imem_addr));
         if (bus.cpen) begin
            q_cpen_cyc.push_back(cyc);
            q_cpen_word.push_back(bus.instruction);
         end
         if (done) done_cnt++;
      end
   end

   task automatic clear_logs();
      q_rd_addr.delete();
      q_cpen_cyc.delete();
      q_cpen_word.delete();
      done_cnt = 0;
   endtask

   // abort_issue >= 0 aborts in the first WAIT_BUSY cycle of that issue.
   task automatic run(input logic [7:0] s, input logic [7:0] e, input int h,
                      input int abort_issue, input bit poke_start);
      logic [7:0] span;
      int endc;
      busy_hold = h;
      @(negedge clk);
      clear_logs();
      span    = e - s;
      m_start = s;
      m_n     = int'(span) + 1;
      m_P     = 3 + ((h > 2) ? h : 2);
      m_A     = cyc + 1;
      m_ab    = (abort_issue >= 0) ? (m_A + abort_issue * m_P + 3) : -1;
      m_en    = 1;
      start_pc = s;
      stop_pc  = e;
      start    = 1;
      endc = (m_ab >= 0) ? m_ab : (m_A + m_n * m_P);
      @(negedge clk);
      start    = 0;
      start_pc = ~s;
      stop_pc  = ~e;
      while (cyc < endc + 3) begin
         @(negedge clk);
         abort = (abort_issue >= 0 && cyc == m_ab);
         start = (poke_start && cyc == m_A + 6);
         if (start) begin
            start_pc = 8'h00;
            stop_pc  = 8'h05;
         end
      end
      abort = 0;
      start = 0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 15'(i * 37 + 5);
      mem[8'h10] = 15'h0003;
      mem[8'h11] = 15'h1105;
      mem[8'h12] = 15'h7FFF;
      mem[8'hFE] = 15'h0AAA;
      mem[8'hFF] = 15'h1234;
      mem[8'h00] = 15'h4321;
      mem[8'h01] = 15'h0555;

      reset = 1; start = 0; abort = 0; start_pc = 8'h00; stop_pc = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 0;

      // Reset values
      chk("rst_cpen", 32'(bus.cpen), 32'd0);
      chk("rst_instruction", 32'(bus.instruction), 32'h02C0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_imem_rd", 32'(imem_rd), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_issue_count", 32'(issue_count), 32'd0);

      chk_on = 1;
      repeat (10) @(negedge clk);

      // Three words, core never busy
      run(8'h10, 8'h12, 0, -1, 0);
      chk("t2_issues", 32'(q_cpen_word.size()), 32'd3);
      chk("t2_word0", 32'(q_cpen_word[0]), 32'h0003);
      chk("t2_word1", 32'(q_cpen_word[1]), 32'h1105);
      chk("t2_word2", 32'(q_cpen_word[2]), 32'h7FFF);
      chk("t2_gap01", 32'(q_cpen_cyc[1] - q_cpen_cyc[0]), 32'd5);
      chk("t2_gap12", 32'(q_cpen_cyc[2] - q_cpen_cyc[1]), 32'd5);
      chk("t2_done_pulses", 32'(done_cnt), 32'd1);
      chk("t2_issue_count", 32'(issue_count), exp_cnt(3));

      // Same program, busy held 4 cycles per instruction
      run(8'h10, 8'h12, 4, -1, 0);
      chk("t3_issues", 32'(q_cpen_word.size()), 32'd3);
      chk("t3_word2", 32'(q_cpen_word[2]), 32'h7FFF);
      chk("t3_gap01", 32'(q_cpen_cyc[1] - q_cpen_cyc[0]), 32'd7);
      chk("t3_done_pulses", 32'(done_cnt), 32'd1);

      // Wrap through the top of the address space
      run(8'hFE, 8'h01, 1, -1, 0);
      chk("t4_fetches", 32'(q_rd_addr.size()), 32'd4);
      chk("t4_addr0", 32'(q_rd_addr[0]), 32'hFE);
      chk("t4_addr1", 32'(q_rd_addr[1]), 32'hFF);
      chk("t4_addr2", 32'(q_rd_addr[2]), 32'h00);
      chk("t4_addr3", 32'(q_rd_addr[3]), 32'h01);
      chk("t4_word2", 32'(q_cpen_word[2]), 32'h4321);
      chk("t4_done_pulses", 32'(done_cnt), 32'd1);
      chk("t4_issue_count", 32'(issue_count), exp_cnt(4));

      // Abort while waiting on the second instruction
      run(8'h10, 8'h12, 0, 1, 0);
      chk("t5_issues", 32'(q_cpen_word.size()), 32'd2);
      chk("t5_done_pulses", 32'(done_cnt), 32'd0);
      chk("t5_instruction", 32'(bus.instruction), 32'h02C0);
      chk("t5_running", 32'(running), 32'd0);
      chk("t5_issue_count", 32'(issue_count), exp_cnt(2));

      // start pulsed mid-run is ignored
      run(8'h10, 8'h12, 3, -1, 1);
      chk("t6_issues", 32'(q_cpen_word.size()), 32'd3);
      chk("t6_word0", 32'(q_cpen_word[0]), 32'h0003);
      chk("t6_done_pulses", 32'(done_cnt), 32'd1);
      chk("t6_issue_count", 32'(issue_count), exp_cnt(3));

      // start and abort together in IDLE: nothing happens
      clear_logs();
      @(negedge clk);
      start = 1; abort = 1; start_pc = 8'h10; stop_pc = 8'h12;
      @(negedge clk);
      start = 0; abort = 0;
      repeat (8) @(negedge clk);
      chk("t7_fetches", 32'(q_rd_addr.size()), 32'd0);
      chk("t7_issues", 32'(q_cpen_word.size()), 32'd0);
      chk("t7_issue_count", 32'(issue_count), exp_cnt(3));

      chk_on = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
